// File: rtl/fht_ctrl_pkg.sv
// Shared constants and FSM encoding for the FHT stage/butterfly sequencer.
// Butterfly latencies describe the fixed pipeline of one fht_but instance.
package fht_ctrl_pkg;

    localparam int N_POINTS = 256;
    localparam int LOG_N    = 8;

    localparam int BUT_LAT_PROD = 1;
    localparam int BUT_LAT_OUT  = 2;
    localparam int BUT_LAT_RW   = BUT_LAT_PROD + BUT_LAT_OUT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fht_ctrl_if.sv
// Control/address bundle between the FHT sequencer and the RAM/ROM/butterfly datapath.
// The sequencer takes the master side; the host/datapath takes the slave side.
interface fht_ctrl_if #(
    parameter int LOG_N  = 8,
    parameter int A_BIT  = 8,
    parameter int WA_BIT = 7
);
    localparam int ST_BIT = $clog2(LOG_N);

    logic              iSTART;
    logic              oBUSY;
    logic              oDONE;
    logic [ST_BIT-1:0] oSTAGE;
    logic              oBANK;
    logic              oRD_EN_12;
    logic [A_BIT-1:0]  oRD_ADDR_1;
    logic [A_BIT-1:0]  oRD_ADDR_2;
    logic [WA_BIT-1:0] oW_ADDR;
    logic              oRD_EN_0;
    logic [A_BIT-1:0]  oRD_ADDR_0;
    logic              oWR_EN;
    logic [A_BIT-1:0]  oWR_ADDR_0;
    logic [A_BIT-1:0]  oWR_ADDR_1;

    modport master (
        input  iSTART,
        output oBUSY, oDONE, oSTAGE, oBANK,
        output oRD_EN_12, oRD_ADDR_1, oRD_ADDR_2, oW_ADDR,
        output oRD_EN_0, oRD_ADDR_0,
        output oWR_EN, oWR_ADDR_0, oWR_ADDR_1
    );

    modport slave (
        output iSTART,
        input  oBUSY, oDONE, oSTAGE, oBANK,
        input  oRD_EN_12, oRD_ADDR_1, oRD_ADDR_2, oW_ADDR,
        input  oRD_EN_0, oRD_ADDR_0,
        input  oWR_EN, oWR_ADDR_0, oWR_ADDR_1
    );

endinterface

// File: rtl/fht_addr_gen.sv
// Combinational (stage, butterfly) -> data/twiddle address mapping for the in-place radix-2 FHT.
// b*L is formed by clearing the low s bits of k and shifting left once.
module fht_addr_gen #(
    parameter int LOG_N  = 8,
    parameter int A_BIT  = 8,
    parameter int WA_BIT = 7,
    parameter int ST_BIT = $clog2(LOG_N),
    parameter int K_BIT  = LOG_N - 1
) (
    input  logic [ST_BIT-1:0] stage,
    input  logic [K_BIT-1:0]  k,
    output logic [A_BIT-1:0]  addr0,
    output logic [A_BIT-1:0]  addr1,
    output logic [A_BIT-1:0]  addr2,
    output logic [WA_BIT-1:0] w_addr
);
    logic [A_BIT-1:0]  kx;
    logic [A_BIT-1:0]  h;
    logic [A_BIT-1:0]  mask;
    logic [A_BIT-1:0]  j;
    logic [A_BIT-1:0]  base;
    logic [ST_BIT-1:0] sh;

    always_comb begin
        kx     = A_BIT'(k);
        h      = A_BIT'(1) << stage;
        mask   = h - A_BIT'(1);
        j      = kx & mask;
        base   = (kx & ~mask) << 1;
        addr0  = base + j;
        addr1  = base + h + j;
        addr2  = base + h + ((h - j) & mask);
        sh     = ST_BIT'(LOG_N - 1) - stage;
        w_addr = WA_BIT'(j) << sh;
    end

endmodule

// File: rtl/fht_ctrl.sv
// FHT sequencer: walks LOG_N stages of N/2 butterflies and delays addresses/strobes
// to line up with the 3-cycle butterfly pipeline.
//   state | meaning
//   IDLE  | waiting for iSTART, all strobes low
//   RUN   | one butterfly issued per cycle, k = 0..N/2-1
//   DRAIN | no issues; pipeline writes of this stage complete
//   DONE  | single-cycle completion pulse
module fht_ctrl #(
    parameter int N_POINTS = fht_ctrl_pkg::N_POINTS,
    parameter int LOG_N    = fht_ctrl_pkg::LOG_N,
    parameter int A_BIT    = LOG_N,
    parameter int WA_BIT   = LOG_N - 1
) (
    input  logic       iCLK,
    input  logic       iRESET,
    fht_ctrl_if.master bus
);
    import fht_ctrl_pkg::*;

    localparam int ST_BIT = $clog2(LOG_N);
    localparam int K_BIT  = LOG_N - 1;
    localparam int RD_TAP = BUT_LAT_PROD - 1;
    localparam int WR_TAP = BUT_LAT_RW - 1;

    localparam logic [K_BIT-1:0]  K_LAST     = K_BIT'(N_POINTS / 2 - 1);
    localparam logic [ST_BIT-1:0] S_LAST     = ST_BIT'(LOG_N - 1);
    localparam logic [1:0]        DRAIN_LOAD = 2'(BUT_LAT_RW - 1);

    state_t            state, state_nx;
    logic [ST_BIT-1:0] stage;
    logic [K_BIT-1:0]  k;
    logic [1:0]        drain_cnt;

    logic [A_BIT-1:0]  g_a0, g_a1, g_a2;
    logic [WA_BIT-1:0] g_w;
    logic              issue;
    logic [A_BIT-1:0]  iss_a0, iss_a1;

    logic [BUT_LAT_RW-1:0]            en_d;
    logic [BUT_LAT_RW-1:0][A_BIT-1:0] a0_d;
    logic [BUT_LAT_RW-1:0][A_BIT-1:0] a1_d;

    fht_addr_gen #(
        .LOG_N  (LOG_N),
        .A_BIT  (A_BIT),
        .WA_BIT (WA_BIT),
        .ST_BIT (ST_BIT),
        .K_BIT  (K_BIT)
    ) u_addr_gen (
        .stage  (stage),
        .k      (k),
        .addr0  (g_a0),
        .addr1  (g_a1),
        .addr2  (g_a2),
        .w_addr (g_w)
    );

    always_ff @(posedge iCLK) begin
        if (iRESET) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (bus.iSTART) state_nx = ST_RUN;
            ST_RUN:   if (k == K_LAST) state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == '0) state_nx = (stage == S_LAST) ? ST_DONE : ST_RUN;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Stage advances on the last DRAIN cycle so oSTAGE/oBANK hold through the drain.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            stage     <= '0;
            k         <= '0;
            drain_cnt <= DRAIN_LOAD;
        end else begin
            case (state)
                ST_RUN: begin
                    k         <= (k == K_LAST) ? '0 : k + 1'b1;
                    drain_cnt <= DRAIN_LOAD;
                end
                ST_DRAIN: begin
                    if (drain_cnt != '0)     drain_cnt <= drain_cnt - 1'b1;
                    else if (stage != S_LAST) stage    <= stage + 1'b1;
                end
                default: begin
                    stage <= '0;
                    k     <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            en_d <= '0;
            a0_d <= '0;
            a1_d <= '0;
        end else begin
            en_d <= {en_d[BUT_LAT_RW-2:0], issue};
            a0_d <= {a0_d[BUT_LAT_RW-2:0], iss_a0};
            a1_d <= {a1_d[BUT_LAT_RW-2:0], iss_a1};
        end
    end

    always_comb begin
        issue          = (state == ST_RUN);
        iss_a0         = issue ? g_a0 : '0;
        iss_a1         = issue ? g_a1 : '0;
        bus.oBUSY      = (state != ST_IDLE);
        bus.oDONE      = (state == ST_DONE);
        bus.oSTAGE     = stage;
        bus.oBANK      = stage[0];
        bus.oRD_EN_12  = issue;
        bus.oRD_ADDR_1 = iss_a1;
        bus.oRD_ADDR_2 = issue ? g_a2 : '0;
        bus.oW_ADDR    = issue ? g_w  : '0;
        bus.oRD_EN_0   = en_d[RD_TAP];
        bus.oRD_ADDR_0 = a0_d[RD_TAP];
        bus.oWR_EN     = en_d[WR_TAP];
        bus.oWR_ADDR_0 = a0_d[WR_TAP];
        bus.oWR_ADDR_1 = a1_d[WR_TAP];
    end

endmodule
